// File: rtl/dct_pkg.sv
// Shared constants for the 8-point DCT column stage: widths, cosine
// coefficients, the coefficient matrix and the saturation limits.
package dct_pkg;

   localparam int IN_W   = 11;
   localparam int OUT_W  = 11;
   localparam int FRAC   = 12;
   localparam int COEF_W = 13;
   localparam int PROD_W = 24;
   localparam int ACC_W  = 27;

   // Cosine magnitudes: round(4096 * a(k) * cos(m*pi/16)).
   localparam logic signed [COEF_W-1:0] C1 = 13'sd2009;
   localparam logic signed [COEF_W-1:0] C2 = 13'sd1892;
   localparam logic signed [COEF_W-1:0] C3 = 13'sd1703;
   localparam logic signed [COEF_W-1:0] C4 = 13'sd1448;
   localparam logic signed [COEF_W-1:0] C5 = 13'sd1138;
   localparam logic signed [COEF_W-1:0] C6 = 13'sd784;
   localparam logic signed [COEF_W-1:0] C7 = 13'sd400;

   // COEF[k][n] = C(k) * cos((2n+1)k*pi/16), row k produces y[k].
   localparam logic signed [COEF_W-1:0] COEF [8][8] = '{
      '{ C4,  C4,  C4,  C4,  C4,  C4,  C4,  C4},
      '{ C1,  C3,  C5,  C7, -C7, -C5, -C3, -C1},
      '{ C2,  C6, -C6, -C2, -C2, -C6,  C6,  C2},
      '{ C3, -C7, -C1, -C5,  C5,  C1,  C7, -C3},
      '{ C4, -C4, -C4,  C4,  C4, -C4, -C4,  C4},
      '{ C5, -C1,  C7,  C3, -C3, -C7,  C1, -C5},
      '{ C6, -C2,  C2, -C6, -C6,  C2, -C2,  C6},
      '{ C7, -C5,  C3, -C1,  C1, -C3,  C5, -C7}
   };

   // Rounding offset and saturation limits, expressed at accumulator width
   // for comparison and at output width for the clamped result.
   localparam logic signed [ACC_W-1:0] ROUND_K  = ACC_W'(2 ** (FRAC - 1));
   localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN  = -ACC_W'(2 ** (OUT_W - 1));
   localparam logic signed [OUT_W-1:0] OUT_MAX  = OUT_W'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [OUT_W-1:0] OUT_MIN  = OUT_W'(2 ** (OUT_W - 1));

endpackage

// File: rtl/dct_lane_mac.sv
// One DCT output lane y[K]: 8 products, two 4-term partial sums, then
// final add, round-half-up and saturate onto the output register.
module dct_lane_mac
   import dct_pkg::*;
#(
   parameter int K = 0
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_en_s1,
   input  logic                     i_en_s2,
   input  logic                     i_en_s3,
   input  logic [7:0][IN_W-1:0]     i_x,
   output logic signed [OUT_W-1:0]  o_y
);

   logic signed [PROD_W-1:0] prod_d [8];
   logic signed [PROD_W-1:0] prod_q [8];
   logic signed [ACC_W-1:0]  sum_lo_d, sum_lo_q;
   logic signed [ACC_W-1:0]  sum_hi_d, sum_hi_q;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  acc_sh;
   logic signed [OUT_W-1:0]  y_d, y_q;

   // S1: multiply each sample by its row coefficient; hold when no vector.
   always_comb begin
      for (int n = 0; n < 8; n++) begin
         prod_d[n] = prod_q[n];
         if (i_en_s1) begin
            prod_d[n] = PROD_W'(COEF[K][n]) * PROD_W'($signed(i_x[n]));
         end
      end
   end

   // S2: lower and upper 4-term partial sums.
   always_comb begin
      sum_lo_d = sum_lo_q;
      sum_hi_d = sum_hi_q;
      if (i_en_s2) begin
         sum_lo_d = ACC_W'(prod_q[0]) + ACC_W'(prod_q[1])
                  + ACC_W'(prod_q[2]) + ACC_W'(prod_q[3]);
         sum_hi_d = ACC_W'(prod_q[4]) + ACC_W'(prod_q[5])
                  + ACC_W'(prod_q[6]) + ACC_W'(prod_q[7]);
      end
   end

   // S3: final add, floor shift after +half (round-half-up), clamp.
   always_comb begin
      acc    = sum_lo_q + sum_hi_q + ROUND_K;
      acc_sh = acc >>> FRAC;
      y_d    = y_q;
      if (i_en_s3) begin
         if (acc_sh > SAT_MAX) begin
            y_d = OUT_MAX;
         end else if (acc_sh < SAT_MIN) begin
            y_d = OUT_MIN;
         end else begin
            y_d = acc_sh[OUT_W-1:0];
         end
      end
   end

   // Pipeline registers for all three stages.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int n = 0; n < 8; n++) begin
            prod_q[n] <= '0;
         end
         sum_lo_q <= '0;
         sum_hi_q <= '0;
         y_q      <= '0;
      end else begin
         for (int n = 0; n < 8; n++) begin
            prod_q[n] <= prod_d[n];
         end
         sum_lo_q <= sum_lo_d;
         sum_hi_q <= sum_hi_d;
         y_q      <= y_d;
      end
   end

   assign o_y = y_q;

endmodule

// File: rtl/dct_1d_8pt.sv
// Pipelined 8-point 1-D DCT-II (column pass). Eight lane MACs compute the
// coefficients; this level carries valid/last alongside the data and
// counts accepted vectors to tag the last vector of each 8x8 block.
module dct_1d_8pt
   import dct_pkg::*;
(
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_valid,
   input  logic signed [IN_W-1:0]   i_data0,
   input  logic signed [IN_W-1:0]   i_data1,
   input  logic signed [IN_W-1:0]   i_data2,
   input  logic signed [IN_W-1:0]   i_data3,
   input  logic signed [IN_W-1:0]   i_data4,
   input  logic signed [IN_W-1:0]   i_data5,
   input  logic signed [IN_W-1:0]   i_data6,
   input  logic signed [IN_W-1:0]   i_data7,
   output logic signed [OUT_W-1:0]  o_data0,
   output logic signed [OUT_W-1:0]  o_data1,
   output logic signed [OUT_W-1:0]  o_data2,
   output logic signed [OUT_W-1:0]  o_data3,
   output logic signed [OUT_W-1:0]  o_data4,
   output logic signed [OUT_W-1:0]  o_data5,
   output logic signed [OUT_W-1:0]  o_data6,
   output logic signed [OUT_W-1:0]  o_data7,
   output logic                     o_valid,
   output logic                     o_last
);

   logic [7:0][IN_W-1:0]    x;
   logic signed [OUT_W-1:0] y [8];

   logic       v1_d, v1_q, v2_d, v2_q, o_valid_d, o_valid_q;
   logic       l1_d, l1_q, l2_d, l2_q, o_last_d, o_last_q;
   logic [2:0] blk_cnt_d, blk_cnt_q;

   assign x[0] = i_data0;
   assign x[1] = i_data1;
   assign x[2] = i_data2;
   assign x[3] = i_data3;
   assign x[4] = i_data4;
   assign x[5] = i_data5;
   assign x[6] = i_data6;
   assign x[7] = i_data7;

   for (genvar k = 0; k < 8; k++) begin : g_lane
      dct_lane_mac #(
         .K (k)
      ) u_lane (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_en_s1 (i_valid),
         .i_en_s2 (v1_q),
         .i_en_s3 (v2_q),
         .i_x     (x),
         .o_y     (y[k])
      );
   end

   // Valid and last tag travel with the data; the block counter advances
   // only on accepted vectors so idle gaps never shift block alignment.
   always_comb begin
      v1_d      = i_valid;
      l1_d      = i_valid && (blk_cnt_q == 3'd7);
      v2_d      = v1_q;
      l2_d      = l1_q;
      o_valid_d = v2_q;
      o_last_d  = l2_q;
      blk_cnt_d = blk_cnt_q;
      if (i_valid) begin
         blk_cnt_d = blk_cnt_q + 3'd1;
      end
   end

   // Control pipeline and block counter registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         o_valid_q <= 1'b0;
         l1_q      <= 1'b0;
         l2_q      <= 1'b0;
         o_last_q  <= 1'b0;
         blk_cnt_q <= 3'd0;
      end else begin
         v1_q      <= v1_d;
         v2_q      <= v2_d;
         o_valid_q <= o_valid_d;
         l1_q      <= l1_d;
         l2_q      <= l2_d;
         o_last_q  <= o_last_d;
         blk_cnt_q <= blk_cnt_d;
      end
   end

   assign o_valid = o_valid_q;
   assign o_last  = o_last_q;
   assign o_data0 = y[0];
   assign o_data1 = y[1];
   assign o_data2 = y[2];
   assign o_data3 = y[3];
   assign o_data4 = y[4];
   assign o_data5 = y[5];
   assign o_data6 = y[6];
   assign o_data7 = y[7];

endmodule

// File: tb/tb_dct_1d_8pt.sv
// Bench for dct_1d_8pt: directed and random vectors checked against a
// real-arithmetic DCT reference and a queue-based latency/last model.
module tb_dct_1d_8pt;

   logic clk = 1'b0;
   logic rst;
   logic i_valid;
   logic [7:0][10:0] xin;
   logic signed [10:0] od [8];
   logic o_valid, o_last;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int acc_cnt = 0;
   int last_cnt = 0;
   int coef_r [8][8];

   typedef struct {
      int               due;
      logic [7:0][10:0] y;
      logic             last;
   } exp_t;

   exp_t q[$];
   logic [7:0][10:0] hold_y;

   always #5 clk = ~clk;

   dct_1d_8pt dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_valid (i_valid),
      .i_data0 (xin[0]), .i_data1 (xin[1]), .i_data2 (xin[2]), .i_data3 (xin[3]),
      .i_data4 (xin[4]), .i_data5 (xin[5]), .i_data6 (xin[6]), .i_data7 (xin[7]),
      .o_data0 (od[0]), .o_data1 (od[1]), .o_data2 (od[2]), .o_data3 (od[3]),
      .o_data4 (od[4]), .o_data5 (od[5]), .o_data6 (od[6]), .o_data7 (od[7]),
      .o_valid (o_valid),
      .o_last  (o_last)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Coefficients from the DCT-II definition using real cosines.
   function automatic void build_coefs();
      real pi, a, v;
      pi = 3.14159265358979323846;
      for (int k = 0; k < 8; k++) begin
         a = (k == 0) ? $sqrt(1.0 / 8.0) : 0.5;
         for (int n = 0; n < 8; n++) begin
            v = 4096.0 * a * $cos(real'((2 * n + 1) * k) * pi / 16.0);
            coef_r[k][n] = $rtoi((v >= 0.0) ? v + 0.5 : v - 0.5);
         end
      end
   endfunction

   function automatic logic [7:0][10:0] dct_ref(input logic [7:0][10:0] x);
      logic [7:0][10:0] y;
      longint s;
      for (int k = 0; k < 8; k++) begin
         s = 0;
         for (int n = 0; n < 8; n++) begin
            s += longint'(coef_r[k][n]) * longint'($signed(x[n]));
         end
         s = (s + 2048) >>> 12;
         if (s > 1023)  s = 1023;
         if (s < -1024) s = -1024;
         y[k] = s[10:0];
      end
      return y;
   endfunction

   function automatic logic [7:0][10:0] rvec();
      logic [7:0][10:0] r;
      for (int k = 0; k < 8; k++) r[k] = 11'($urandom_range(0, 2047));
      return r;
   endfunction

   function automatic logic [7:0][10:0] fill(input int v);
      logic [7:0][10:0] r;
      for (int k = 0; k < 8; k++) r[k] = 11'(v);
      return r;
   endfunction

   // One cycle: check outputs against the model, then drive the next input.
   task automatic step(input bit v, input logic [7:0][10:0] x);
      exp_t e;
      @(negedge clk);
      cyc++;
      if (o_last === 1'b1) last_cnt++;
      if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         chk("valid", 32'(o_valid), 1);
         chk("last", 32'(o_last), 32'(e.last));
         for (int k = 0; k < 8; k++) chk($sformatf("y%0d", k), od[k], $signed(e.y[k]));
         hold_y = e.y;
      end else begin
         chk("idle_valid", 32'(o_valid), 0);
         chk("idle_last", 32'(o_last), 0);
         for (int k = 0; k < 8; k++) chk($sformatf("hold_y%0d", k), od[k], $signed(hold_y[k]));
      end
      i_valid = v;
      xin = v ? x : rvec();
      if (v) begin
         e.due  = cyc + 3;
         e.y    = dct_ref(x);
         e.last = ((acc_cnt % 8) == 7);
         q.push_back(e);
         acc_cnt++;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      i_valid = 1'b0;
      rst = 1'b1;
      q.delete();
      acc_cnt = 0;
      hold_y = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int l0;
      logic [7:0][10:0] imp;
      build_coefs();
      rst = 1'b1;
      i_valid = 1'b0;
      xin = '0;
      hold_y = '0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_last", 32'(o_last), 0);
      for (int k = 0; k < 8; k++) chk($sformatf("rst_y%0d", k), od[k], 0);
      rst = 1'b0;

      // DC vector
      step(1'b1, fill(100));
      idle(3);
      chk("dc_y0", od[0], 283);
      chk("dc_y1", od[1], 0);
      chk("dc_last", 32'(o_last), 0);

      // Impulse
      imp = '0;
      imp[0] = 11'd1000;
      step(1'b1, imp);
      idle(3);
      chk("imp_y0", od[0], 354);
      chk("imp_y1", od[1], 490);

      // Saturation both directions
      step(1'b1, fill(1023));
      idle(3);
      chk("satp_y0", od[0], 1023);
      chk("satp_y7", od[7], 0);
      step(1'b1, fill(-1024));
      idle(3);
      chk("satn_y0", od[0], -1024);
      chk("satn_y3", od[3], 0);

      // Burst of 16 back-to-back from a fresh block
      do_reset();
      l0 = last_cnt;
      for (int i = 0; i < 16; i++) step(1'b1, rvec());
      idle(4);
      chk("burst_lasts", last_cnt - l0, 2);

      // One block with random gaps
      l0 = last_cnt;
      for (int i = 0; i < 8; i++) begin
         step(1'b1, rvec());
         idle($urandom_range(0, 5));
      end
      idle(4);
      chk("gap_lasts", last_cnt - l0, 1);

      // Asynchronous reset with vectors in flight
      for (int i = 0; i < 5; i++) step(1'b1, rvec());
      #1;
      i_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(o_valid), 0);
      chk("arst_last", 32'(o_last), 0);
      chk("arst_y0", od[0], 0);
      q.delete();
      acc_cnt = 0;
      hold_y = '0;
      repeat (2) @(negedge clk);
      chk("arst_hold_valid", 32'(o_valid), 0);
      rst = 1'b0;
      idle(4);
      l0 = last_cnt;
      for (int i = 0; i < 8; i++) step(1'b1, rvec());
      idle(4);
      chk("post_rst_lasts", last_cnt - l0, 1);

      // Random mix of valid and bubbles
      for (int i = 0; i < 60; i++) step(1'($urandom_range(0, 1)), rvec());
      idle(4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
